// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared CPU pipeline types and widths
// Revision      : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pctrl_state_t;

  localparam int STALL_CNT_W = 16;
  localparam int FLUSH_CNT_W = 8;

  // A load into r0 never creates a dependency.
  function automatic logic is_load_use(input logic     mem_read,
                                       input regbits_t wsel,
                                       input regbits_t rs,
                                       input regbits_t rt);
    return mem_read & (wsel != '0) & ((wsel == rs) | (wsel == rt));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// pipeline_ctrl_if : hazard-unit inputs and pipeline-control outputs
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if import cpu_types_pkg::*; ();

  logic         ihit;
  logic         dhit;
  logic         dmemREN_3;
  logic         dmemWEN_3;
  logic         MemRead_out_2;
  regbits_t     wsel_out_2;
  regbits_t     rs_out_1;
  regbits_t     rt_out_1;
  logic         PCSrc_3;
  logic         halt_out_4;

  logic         pc_en;
  logic         ifid_en;
  logic         idex_en;
  logic         exmem_en;
  logic         memwb_en;
  logic         ifid_flush;
  logic         idex_flush;
  logic         exmem_flush;
  logic         halt;
  pctrl_state_t state;
  logic [15:0]  stall_cnt;
  logic [7:0]   flush_cnt;

  modport pc (
    input  ihit, dhit, dmemREN_3, dmemWEN_3, MemRead_out_2, wsel_out_2,
           rs_out_1, rt_out_1, PCSrc_3, halt_out_4,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, state,
           stall_cnt, flush_cnt
  );

  modport tb (
    output ihit, dhit, dmemREN_3, dmemWEN_3, MemRead_out_2, wsel_out_2,
           rs_out_1, rt_out_1, PCSrc_3, halt_out_4,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, state,
           stall_cnt, flush_cnt
  );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl : 5-stage pipeline stall/flush/halt controller
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  pipeline_ctrl_if.pc bus
);

  pctrl_state_t           state_q;
  pctrl_state_t           state_d;
  logic                   w_dmem_pend;
  logic                   w_load_use;
  logic                   w_run_dec;
  logic                   w_halt;
  logic [4:0]             w_en;     // {pc, ifid, idex, exmem, memwb}
  logic [2:0]             w_flush;  // {ifid, idex, exmem}
  logic                   w_stall_inc;
  logic                   w_flush_inc;
  logic [STALL_CNT_W-1:0] w_stall_cnt;
  logic [FLUSH_CNT_W-1:0] w_flush_cnt;

  assign w_dmem_pend = (bus.dmemREN_3 | bus.dmemWEN_3) & ~bus.dhit;
  assign w_load_use  = is_load_use(bus.MemRead_out_2, bus.wsel_out_2,
                                   bus.rs_out_1, bus.rt_out_1);

  // A halt reaching MEM/WB freezes everything in its cycle, overriding any
  // branch or memory wait that shows up alongside it.
  always_comb begin
    state_d   = state_q;
    w_run_dec = 1'b0;
    w_halt    = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.halt_out_4)   state_d = HALT;
        else if (w_dmem_pend) state_d = DWAIT;
        else                  w_run_dec = 1'b1;
      end
      DWAIT: begin
        if (bus.halt_out_4) begin
          state_d = HALT;
        end else if (bus.dhit) begin
          state_d   = RUN;
          w_run_dec = 1'b1;
        end
      end
      HALT:    w_halt  = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    w_en    = 5'b00000;
    w_flush = 3'b000;
    if (w_run_dec) begin
      if (bus.PCSrc_3) begin
        w_en    = 5'b11111;
        w_flush = 3'b111;
      end else if (w_load_use) begin
        w_en    = 5'b00111;
        w_flush = 3'b010;
      end else if (!bus.ihit) begin
        w_en    = 5'b01111;
        w_flush = 3'b100;
      end else begin
        w_en    = 5'b11111;
      end
    end
  end

  assign w_stall_inc = (state_q != HALT) & ~w_en[4];
  assign w_flush_inc = w_run_dec & bus.PCSrc_3;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_stall_inc),
    .count (w_stall_cnt)
  );

  sat_counter #(.WIDTH(FLUSH_CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_flush_inc),
    .count (w_flush_cnt)
  );

  assign bus.pc_en       = w_en[4];
  assign bus.ifid_en     = w_en[3];
  assign bus.idex_en     = w_en[2];
  assign bus.exmem_en    = w_en[1];
  assign bus.memwb_en    = w_en[0];
  assign bus.ifid_flush  = w_flush[2];
  assign bus.idex_flush  = w_flush[1];
  assign bus.exmem_flush = w_flush[0];
  assign bus.halt        = w_halt;
  assign bus.state       = state_q;
  assign bus.stall_cnt   = w_stall_cnt;
  assign bus.flush_cnt   = w_flush_cnt;

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports, in order:
  - CLK  in  1  rising-edge clock.
  - nRST  in  1  reset; synchronous, active-low.
  - ihit  in  1  instruction fetch complete this cycle.
  - dhit  in  1  data access complete this cycle.
  - dmemREN_3, dmemWEN_3  in  1 each  EX/MEM latch holds a load/store.
  - MemRead_out_2  in  1  ID/EX latch holds a load.
  - wsel_out_2  in  regbits_t  destination register of the ID/EX load.
  - rs_out_1, rt_out_1  in  regbits_t  source registers of the IF/ID instruction.
  - PCSrc_3  in  1  taken branch/jump resolved at the EX/MEM latch.
  - halt_out_4  in  1  MEM/WB latch holds a halt.
  - pc_en  out  1  PC update enable.
  - ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline latch enables.
  - ifid_flush, idex_flush, exmem_flush  out  1 each  latch loads a bubble (nop) when also enabled.
  - halt  out  1  sticky halt indication.
  - state  out  pctrl_state_t  current FSM state.
  - stall_cnt  out  16  saturating count of cycles with pc_en=0 (HALT excluded).
  - flush_cnt  out  8  saturating count of branch flush events.

Function
REQ-002 SHALL implement FSM states RUN, DWAIT, HALT; state is registered; all other outputs except the counters are combinational from state and inputs.
REQ-003 dmem_pend SHALL equal (dmemREN_3 | dmemWEN_3) & ~dhit.
REQ-004 load_use SHALL equal MemRead_out_2 & (wsel_out_2 != 0) & (wsel_out_2 == rs_out_1 | wsel_out_2 == rt_out_1).
REQ-005 Transitions: RUN->DWAIT on dmem_pend; DWAIT->RUN on dhit; RUN or DWAIT ->HALT when halt_out_4=1; HALT has no exit except reset.
REQ-006 The halt transition SHALL take priority over all others.
REQ-007 In RUN, conditions SHALL be applied in the priority order given in REQ-008 to REQ-012; the first match wins.
REQ-008 In RUN with dmem_pend: all enables=0, all flushes=0; the pipeline is fully frozen.
REQ-009 In RUN with PCSrc_3: all enables=1; ifid_flush=idex_flush=exmem_flush=1; PC takes the target; flush_cnt increments by one.
REQ-010 In RUN with load_use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1; exactly one bubble is inserted per hazard instance.
REQ-011 In RUN with ~ihit: pc_en=0, ifid_en=1, ifid_flush=1, remaining latches enabled; younger stages drain.
REQ-012 In RUN with no condition: all enables=1, all flushes=0.
REQ-013 In DWAIT with ~dhit: outputs SHALL be as in REQ-008.
REQ-014 In DWAIT with dhit: outputs SHALL be evaluated exactly as RUN without the dmem_pend term, so a pending PCSrc_3 or load_use is applied on the dhit cycle.
REQ-015 In HALT: all enables=0, all flushes=0, halt=1.
REQ-016 halt SHALL be 0 in all other states.
REQ-017 stall_cnt SHALL increment by one on each cycle with pc_en=0 in RUN or DWAIT, saturate at 16'hFFFF, and not wrap.
REQ-018 flush_cnt SHALL saturate at 8'hFF and not wrap.
REQ-019 halt_out_4 SHALL win when asserted in the same cycle as PCSrc_3 or dmem_pend; flush_cnt SHALL not increment in that cycle.

Reset
REQ-020 When nRST=0 at a rising CLK edge: state<=RUN, stall_cnt<=0, flush_cnt<=0.
REQ-021 Reset SHALL take effect from any state, including mid-DWAIT and HALT; pending hazards are discarded.
REQ-022 During reset, outputs SHALL follow RUN decoding of the current inputs after the reset edge; the post-reset output values are pc_en=1, halt=0, counters=0.

Structure
REQ-023 pctrl_state_t (2-bit enum: RUN, DWAIT, HALT) SHALL be added to cpu_types_pkg; regbits_t SHALL be reused from it.
REQ-024 Counters SHALL use one parameterised sub-module sat_counter (parameter WIDTH; ports CLK, nRST, inc, count), instantiated twice.
REQ-025 A companion interface pipeline_ctrl_if SHALL provide modports pc (block) and tb (bench).

Verification
REQ-026 Load-use: MemRead_out_2=1, wsel_out_2=5, rs_out_1=5, ihit=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1 next cycle.
REQ-027 Zero register: same stimulus with wsel_out_2=0 -> no stall; pc_en=1.
REQ-028 Data wait: dmemREN_3=1, dhit=0 for 3 cycles then dhit=1 -> state DWAIT for 3 cycles, all enables 0, stall_cnt=3; on the dhit cycle all enables=1.
REQ-029 Branch during wait: PCSrc_3=1 held through a DWAIT period -> flushes asserted only on the dhit cycle; flush_cnt=1.
REQ-030 Halt priority and stickiness: halt_out_4=1 together with PCSrc_3=1 -> next state HALT, halt=1, flush_cnt unchanged; HALT held for 10 cycles; nRST=0 then returns RUN with counters=0.
REQ-031 Saturation: 70000 consecutive ~ihit cycles -> stall_cnt=16'hFFFF and stays; 300 branch flushes -> flush_cnt=8'hFF.
